demux_thicc_reg: RTL and testbench

DEMUX_THICC_REG -- requirements
Module: demux_thicc_reg

---
 rtl/demux_thicc_reg_pkg.sv | 16 +
 rtl/demux_thicc_reg_slice.sv | 24 ++
 rtl/demux_thicc_reg.sv | 91 +++++++++
 tb/tb_demux_thicc_reg.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_thicc_reg_pkg.sv
// Shared slot-count, index-width and default data-width definitions
// for the write-side demux and its companion read-side multiplexer.
package demux_thicc_reg_pkg;

    localparam int SLOTS     = 16;
    localparam int IDX_W     = 4;
    localparam int DEF_WIDTH = 8;

    typedef logic [SLOTS-1:0] slot_mask_t;
    typedef logic [IDX_W-1:0] slot_idx_t;

    function automatic slot_mask_t onehot(input slot_idx_t idx);
        onehot = slot_mask_t'(1) << idx;
    endfunction

endpackage

// File: rtl/demux_thicc_reg_slice.sv
// One WIDTH-bit storage slot: load, synchronous clear (dominant),
// asynchronous active-low reset.
module reg_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/demux_thicc_reg.sv
// Registered 1-to-16 demux: writes land in one of sixteen slots and
// are tracked by a written mask plus a one-cycle write acknowledge.
module demux_thicc_reg
    import demux_thicc_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [3:0]       select,
    input  logic             write_en,
    input  logic             clear,
    output logic [WIDTH-1:0] out_0,
    output logic [WIDTH-1:0] out_1,
    output logic [WIDTH-1:0] out_2,
    output logic [WIDTH-1:0] out_3,
    output logic [WIDTH-1:0] out_4,
    output logic [WIDTH-1:0] out_5,
    output logic [WIDTH-1:0] out_6,
    output logic [WIDTH-1:0] out_7,
    output logic [WIDTH-1:0] out_8,
    output logic [WIDTH-1:0] out_9,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [WIDTH-1:0] out_e,
    output logic [WIDTH-1:0] out_f,
    output logic [15:0]      written,
    output logic             wr_done,
    output logic [3:0]       wr_index
);

    slot_mask_t       load;
    logic [WIDTH-1:0] q [SLOTS];

    // Gate with write_en first so an unknown select never reaches a slot.
    always_comb begin
        load = '0;
        if (write_en && !clear) begin
            load = onehot(select);
        end
    end

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        reg_slice #(.WIDTH(WIDTH)) u_slice (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[i]),
            .clear (clear),
            .d     (in),
            .q     (q[i])
        );
    end

    assign out_0 = q[0];
    assign out_1 = q[1];
    assign out_2 = q[2];
    assign out_3 = q[3];
    assign out_4 = q[4];
    assign out_5 = q[5];
    assign out_6 = q[6];
    assign out_7 = q[7];
    assign out_8 = q[8];
    assign out_9 = q[9];
    assign out_a = q[10];
    assign out_b = q[11];
    assign out_c = q[12];
    assign out_d = q[13];
    assign out_e = q[14];
    assign out_f = q[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written  <= '0;
            wr_done  <= 1'b0;
            wr_index <= '0;
        end else if (clear) begin
            written  <= '0;
            wr_done  <= 1'b0;
        end else if (write_en) begin
            written  <= written | load;
            wr_done  <= 1'b1;
            wr_index <= select;
        end else begin
            wr_done  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux_thicc_reg.sv
// Randomized and directed bench for demux_thicc_reg against a
// slot-array reference model.
module tb_demux_thicc_reg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in = '0;
    logic [3:0] select = '0;
    logic       write_en = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7;
    logic [7:0] out_8, out_9, out_a, out_b, out_c, out_d, out_e, out_f;
    logic [15:0] written;
    logic        wr_done;
    logic [3:0]  wr_index;

    int total = 0;
    int bad = 0;

    logic [7:0]  m_slot [16];
    logic [15:0] m_written;
    logic        m_done;
    logic [3:0]  m_idx;

    demux_thicc_reg #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .select(select),
        .write_en(write_en), .clear(clear),
        .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3),
        .out_4(out_4), .out_5(out_5), .out_6(out_6), .out_7(out_7),
        .out_8(out_8), .out_9(out_9), .out_a(out_a), .out_b(out_b),
        .out_c(out_c), .out_d(out_d), .out_e(out_e), .out_f(out_f),
        .written(written), .wr_done(wr_done), .wr_index(wr_index)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] dut_outs();
        return {out_f, out_e, out_d, out_c, out_b, out_a, out_9, out_8,
                out_7, out_6, out_5, out_4, out_3, out_2, out_1, out_0};
    endfunction

    function automatic logic [127:0] exp_outs();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = m_slot[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_slot[i] = 8'h00;
        m_written = '0;
        m_done = 1'b0;
        m_idx = '0;
    endtask

    // One clock: rising edge, reference update, then park on falling edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (clear) begin
            for (int i = 0; i < 16; i++) m_slot[i] = 8'h00;
            m_written = '0;
            m_done = 1'b0;
        end else if (write_en) begin
            m_slot[select] = in;
            m_written[select] = 1'b1;
            m_done = 1'b1;
            m_idx = select;
        end else begin
            m_done = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [3:0] s,
                         input logic [7:0] d);
        write_en = we;
        select = s;
        in = d;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        drive(1'b1, 4'h3, 8'hFF);
        step();
        step();
        total++;
        if (dut_outs() !== '0) begin
            bad++;
            $display("FAIL reset_outs got=%h exp=0", dut_outs());
        end
        total++;
        if (written !== 16'h0 || wr_done !== 1'b0 || wr_index !== 4'h0) begin
            bad++;
            $display("FAIL reset_flags got=%h/%b/%h exp=0000/0/0",
                     written, wr_done, wr_index);
        end
        rst_n = 1'b1;
        drive(1'b1, 4'hA, 8'h3C);
        step();
        total++;
        if (out_a !== 8'h3C || wr_done !== 1'b1 || wr_index !== 4'hA) begin
            bad++;
            $display("FAIL first_edge_write got=%h/%b/%h exp=3c/1/a",
                     out_a, wr_done, wr_index);
        end
        clear = 1'b1;
        drive(1'b0, 4'h0, 8'h00);
        step();
        clear = 1'b0;
    endtask

    task automatic test_single();
        drive(1'b1, 4'h1, 8'h11);
        step();
        total++;
        if (wr_done !== 1'b1 || wr_index !== 4'h1 || out_1 !== 8'h11) begin
            bad++;
            $display("FAIL single_w1 got=%b/%h/%h exp=1/1/11",
                     wr_done, wr_index, out_1);
        end
        drive(1'b1, 4'hF, 8'h1F);
        step();
        total++;
        if (wr_done !== 1'b1 || wr_index !== 4'hF || out_f !== 8'h1F) begin
            bad++;
            $display("FAIL single_wf got=%b/%h/%h exp=1/f/1f",
                     wr_done, wr_index, out_f);
        end
        drive(1'b0, 4'h0, 8'h00);
        step();
        total++;
        if (wr_done !== 1'b0 || wr_index !== 4'hF || written !== 16'h8002) begin
            bad++;
            $display("FAIL single_idle got=%b/%h/%h exp=0/f/8002",
                     wr_done, wr_index, written);
        end
        total++;
        if (dut_outs() !== exp_outs() || out_e !== 8'h00) begin
            bad++;
            $display("FAIL single_outs got=%h exp=%h", dut_outs(), exp_outs());
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] sel [3];
        logic [7:0] dat [3];
        sel = '{4'h2, 4'h3, 4'h2};
        dat = '{8'h12, 8'h13, 8'h22};
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, sel[i], dat[i]);
            step();
            total++;
            if (wr_done !== 1'b1 || wr_index !== sel[i]) begin
                bad++;
                $display("FAIL b2b_ack%0d got=%b/%h exp=1/%h",
                         i, wr_done, wr_index, sel[i]);
            end
        end
        drive(1'b0, 4'h0, 8'h00);
        step();
        total++;
        if (out_2 !== 8'h22 || out_3 !== 8'h13 || written !== 16'h000C ||
            wr_done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_final got=%h/%h/%h/%b exp=22/13/000c/0",
                     out_2, out_3, written, wr_done);
        end
    endtask

    task automatic test_clear_write();
        drive(1'b1, 4'h9, 8'h99);
        step();
        clear = 1'b1;
        drive(1'b1, 4'h5, 8'hAA);
        step();
        clear = 1'b0;
        drive(1'b0, 4'h0, 8'h00);
        total++;
        if (dut_outs() !== '0 || written !== 16'h0 || wr_done !== 1'b0) begin
            bad++;
            $display("FAIL clr_write got=%h/%h/%b exp=0/0000/0",
                     dut_outs(), written, wr_done);
        end
        total++;
        if (wr_index !== 4'h9) begin
            bad++;
            $display("FAIL clr_index got=%h exp=9", wr_index);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 4'h7, 8'h55);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (out_7 !== 8'h00 || wr_done !== 1'b0 || written !== 16'h0) begin
            bad++;
            $display("FAIL async_rst got=%h/%b/%h exp=00/0/0000",
                     out_7, wr_done, written);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 4'h0, 8'h00);
        step();
        total++;
        if (wr_done !== 1'b0 || out_7 !== 8'h00 || wr_index !== 4'h0) begin
            bad++;
            $display("FAIL async_release got=%b/%h/%h exp=0/00/0",
                     wr_done, out_7, wr_index);
        end
    endtask

    task automatic test_hold_x();
        drive(1'b1, 4'h6, 8'h66);
        step();
        write_en = 1'b0;
        select = 'x;
        in = 'x;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (dut_outs() !== exp_outs() || written !== m_written ||
                wr_done !== 1'b0) begin
                bad++;
                $display("FAIL hold_x%0d got=%h/%h exp=%h/%h",
                         i, dut_outs(), written, exp_outs(), m_written);
            end
        end
        drive(1'b0, 4'h0, 8'h00);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            clear = ($urandom_range(0, 19) == 0);
            drive($urandom_range(0, 3) != 0, 4'($urandom), 8'($urandom));
            step();
            total++;
            if (dut_outs() !== exp_outs() || written !== m_written ||
                wr_done !== m_done || wr_index !== m_idx) begin
                bad++;
                $display("FAIL rand%0d got=%h/%h/%b/%h exp=%h/%h/%b/%h",
                         i, dut_outs(), written, wr_done, wr_index,
                         exp_outs(), m_written, m_done, m_idx);
            end
        end
        clear = 1'b0;
        drive(1'b0, 4'h0, 8'h00);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_clear_write();
        test_async_reset();
        test_hold_x();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
